// File: rtl/uart_tx_arbiter_if.sv
// Bundle of producer/transmitter-side signals for the two-requester UART TX arbiter.
//
// Handshake semantics (one place, applies to both requesters):
//   reqN is a level "valid": once raised it stays high, with dataN stable, until
//   the arbiter answers with a one-cycle ackN pulse in the cycle the byte is
//   loaded. tx_rdy is the transmitter's "ready": a byte is only loaded when it
//   was high, and tx_write is a one-cycle load strobe with tx_data valid in
//   that cycle (tx_data then holds its value).
interface uart_tx_arbiter_if #(
  parameter int CNTW = 16
);
  logic            req0;
  logic [7:0]      data0;
  logic            req1;
  logic [7:0]      data1;
  logic            tx_rdy;
  logic            ack0;
  logic            ack1;
  logic            tx_write;
  logic [7:0]      tx_data;
  logic            owner;
  logic            busy;
  logic [CNTW-1:0] cnt0;
  logic [CNTW-1:0] cnt1;
  logic [2:0]      dbg_state;

  // Producers and transmitter side
  modport master (
    output req0, data0, req1, data1, tx_rdy,
    input  ack0, ack1, tx_write, tx_data, owner, busy, cnt0, cnt1, dbg_state
  );

  // Arbiter side
  modport slave (
    input  req0, data0, req1, data1, tx_rdy,
    output ack0, ack1, tx_write, tx_data, owner, busy, cnt0, cnt1, dbg_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte producers.
// Issues a one-cycle load strobe, waits for the transmitter to become ready
// again, then inserts GAP idle cycles before the next grant. Keeps wrapping
// per-requester grant counters for debug readback. All outputs registered.
module uart_tx_arbiter #(
  parameter int GAP  = 2,
  parameter int CNTW = 16
) (
  input logic             clk,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_HOLD     = 3'd2;
  localparam logic [2:0] S_WAIT_RDY = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;

  // Value loaded into the gap counter on entry to S_GAP; unused when GAP is 0.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [2:0]      state;
  logic [3:0]      gap_cnt;
  logic            ptr;
  logic            win;
  logic            ack0_q;
  logic            ack1_q;
  logic            tx_write_q;
  logic [7:0]      tx_data_q;
  logic            owner_q;
  logic            busy_q;
  logic [CNTW-1:0] cnt0_q;
  logic [CNTW-1:0] cnt1_q;

  // Winner: a lone requester wins; under contention the pointer decides.
  assign win = (bus.req0 && bus.req1) ? ptr : bus.req1;

  // Main sequencer: grant, strobe, wait for transmitter ready, guard gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      gap_cnt    <= 4'd0;
      ptr        <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      tx_write_q <= 1'b0;
      tx_data_q  <= 8'h00;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      tx_write_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.tx_rdy && (bus.req0 || bus.req1)) begin
            state      <= S_LOAD;
            busy_q     <= 1'b1;
            tx_write_q <= 1'b1;
            tx_data_q  <= win ? bus.data1 : bus.data0;
            ack0_q     <= ~win;
            ack1_q     <= win;
            owner_q    <= win;
            ptr        <= ~win;
            if (win) cnt1_q <= cnt1_q + CNTW'(1);
            else     cnt0_q <= cnt0_q + CNTW'(1);
          end
        end
        S_LOAD: state <= S_HOLD;
        // The transmitter needs a cycle to drop tx_rdy after a load.
        S_HOLD: state <= S_WAIT_RDY;
        S_WAIT_RDY: begin
          if (bus.tx_rdy) begin
            if (GAP == 0) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.tx_write  = tx_write_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a timeline-based reference model.
module tb_uart_tx_arbiter;

  localparam int GAP_P  = 2;
  localparam int CNTW_P = 6;
  localparam int CMASK  = (1 << CNTW_P) - 1;

  logic clk;
  logic reset;

  uart_tx_arbiter_if #(.CNTW(CNTW_P)) bus ();

  uart_tx_arbiter #(.GAP(GAP_P), .CNTW(CNTW_P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic keep0 = 1'b0;
  logic keep1 = 1'b0;

  logic [7:0] exp_q[$];
  int         strobe_cyc[$];
  logic [7:0] strobe_byte[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Timeline view: after a grant at edge N the transmitter's ready is first
  // consulted at edge N+3; ready seen at edge M makes the arbiter free to
  // grant again from edge M+1+GAP. Pointer names the requester that did not
  // win last.
  logic m_valid = 1'b0;
  logic m_waiting, m_ptr, m_owner, m_write, m_ack0, m_ack1, m_busy;
  logic [7:0] m_data;
  int m_cnt0, m_cnt1, avail, wait_from;

  initial begin
    logic win;
    forever begin
      @(posedge clk);
      cyc++;
      m_write = 1'b0;
      m_ack0  = 1'b0;
      m_ack1  = 1'b0;
      if (reset) begin
        m_valid = 1'b1; m_waiting = 1'b0; m_ptr = 1'b0; m_owner = 1'b0;
        m_data = 8'h00; m_cnt0 = 0; m_cnt1 = 0; avail = cyc + 1; wait_from = 0;
        exp_q.delete();
      end else if (m_valid) begin
        if (!m_waiting) begin
          if (cyc >= avail && bus.tx_rdy && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) win = m_ptr;
            else win = bus.req1;
            m_data  = win ? bus.data1 : bus.data0;
            m_write = 1'b1;
            m_ack0  = !win;
            m_ack1  = win;
            m_owner = win;
            m_ptr   = !win;
            if (win) m_cnt1 = (m_cnt1 + 1) & CMASK;
            else     m_cnt0 = (m_cnt0 + 1) & CMASK;
            exp_q.push_back(m_data);
            m_waiting = 1'b1;
            wait_from = cyc + 3;
          end
        end else if (cyc >= wait_from && bus.tx_rdy) begin
          m_waiting = 1'b0;
          avail = cyc + 1 + GAP_P;
        end
      end
      m_busy = m_waiting || (cyc + 1 < avail);
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  initial begin
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("ctl{write,ack0,ack1,owner,busy}",
              32'({bus.tx_write, bus.ack0, bus.ack1, bus.owner, bus.busy}),
              32'({m_write, m_ack0, m_ack1, m_owner, m_busy}));
        check("tx_data", 32'(bus.tx_data), 32'(m_data));
        check("cnt0", 32'(bus.cnt0), m_cnt0);
        check("cnt1", 32'(bus.cnt1), m_cnt1);
        if (bus.tx_write) begin
          strobe_cyc.push_back(cyc);
          strobe_byte.push_back(bus.tx_data);
          if (exp_q.size() == 0) begin
            check("sb_unexpected_strobe", 32'(exp_q.size()), 1);
          end else begin
            want = exp_q.pop_front();
            check("sb_byte", 32'(bus.tx_data), 32'(want));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk); #1;
    if (bus.ack0 && !keep0) bus.req0 = 1'b0;
    if (bus.ack1 && !keep1) bus.req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0; bus.tx_rdy = 1'b1;
    keep0 = 1'b0; keep1 = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    int n = 0;
    int start = strobe_cyc.size();
    while (strobe_cyc.size() == start && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(strobe_cyc.size() - start), 1);
  endtask

  task automatic rand_cycle(input int mode);
    @(negedge clk); #1;
    reset = ($urandom_range(0, 599) == 0);
    bus.tx_rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);
    if (bus.ack0) begin
      if ($urandom_range(0, 3) != 0) bus.req0 = 1'b0;
    end else if (bus.req0) begin
      if ($urandom_range(0, 59) == 0) bus.req0 = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      bus.req0 = 1'b1; bus.data0 = 8'($urandom);
    end
    if (bus.ack1) begin
      if ($urandom_range(0, 3) != 0) bus.req1 = 1'b0;
    end else if (bus.req1) begin
      if ($urandom_range(0, 59) == 0) bus.req1 = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      bus.req1 = 1'b1; bus.data1 = 8'($urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, c, bad;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = 8'h00; bus.data1 = 8'h00;
    bus.tx_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    do_reset();
    check("rst_ctl", 32'({bus.tx_write, bus.ack0, bus.ack1, bus.owner, bus.busy}), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_cnt", 32'({bus.cnt0, bus.cnt1}), 0);

    // Single request from requester 0
    bus.data0 = 8'hAA; bus.req0 = 1'b1;
    wait_strobe("t1_strobe", 10);
    check("t1_data", 32'(bus.tx_data), 32'h00AA);
    check("t1_ack0", 32'({bus.ack0, bus.ack1}), 32'b10);
    check("t1_cnt0", 32'(bus.cnt0), 1);
    check("t1_owner", 32'(bus.owner), 0);
    tick();
    check("t1_one_cycle", 32'({bus.tx_write, bus.ack0}), 0);
    repeat (8) tick();

    // Contention with tx_rdy stuck high: strict alternation, 4+GAP spacing
    do_reset();
    bus.data0 = 8'h11; bus.data1 = 8'h22; keep0 = 1'b1; keep1 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    s = strobe_cyc.size();
    for (int i = 0; i < 4; i++) wait_strobe("t2_strobe", 20);
    check("t2_cnts", 32'({bus.cnt0, bus.cnt1}), 32'({6'd2, 6'd2}));
    if (strobe_cyc.size() >= s + 4) begin
      check("t2_seq", {strobe_byte[s], strobe_byte[s+1], strobe_byte[s+2], strobe_byte[s+3]},
            32'h11221122);
      for (int i = 0; i < 3; i++)
        check("t2_spacing", 32'(strobe_cyc[s+i+1] - strobe_cyc[s+i]), 32'(4 + GAP_P));
    end
    keep0 = 1'b0; keep1 = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (10) tick();

    // tx_rdy low for 20 cycles after a strobe
    do_reset();
    bus.data0 = 8'h5A; bus.req0 = 1'b1;
    wait_strobe("t3_first", 10);
    bus.tx_rdy = 1'b0;
    bus.data1 = 8'h77; bus.req1 = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.busy || bus.tx_write) bad++;
    end
    check("t3_busy_no_strobe", 32'(bad), 0);
    bus.tx_rdy = 1'b1;
    c = cyc;
    wait_strobe("t3_second", 20);
    check("t3_latency", 32'(cyc - c), 32'(2 + GAP_P));
    check("t3_data", 32'(bus.tx_data), 32'h0077);
    repeat (10) tick();

    // tx_rdy low in IDLE blocks the grant
    do_reset();
    bus.tx_rdy = 1'b0; bus.data1 = 8'hC3; bus.req1 = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.tx_write) bad++;
    end
    check("t4_no_strobe", 32'(bad), 0);
    bus.tx_rdy = 1'b1;
    c = cyc;
    wait_strobe("t4_strobe", 10);
    check("t4_latency", 32'(cyc - c), 1);
    check("t4_data_ack1", 32'({bus.tx_data, bus.ack1, bus.owner}), 32'({8'hC3, 1'b1, 1'b1}));
    repeat (10) tick();

    // Reset during WAIT_RDY
    do_reset();
    bus.data0 = 8'h0F; bus.req0 = 1'b1;
    wait_strobe("t5_first", 10);
    bus.tx_rdy = 1'b0;
    repeat (4) tick();
    check("t5_waiting_busy", 32'(bus.busy), 1);
    reset = 1'b1; bus.data1 = 8'hE1; bus.req1 = 1'b1;
    tick();
    check("t5_rst_ctl", 32'({bus.tx_write, bus.ack0, bus.ack1, bus.owner, bus.busy}), 0);
    check("t5_rst_data_cnt", 32'({bus.tx_data, bus.cnt0, bus.cnt1}), 0);
    reset = 1'b0; bus.tx_rdy = 1'b1;
    wait_strobe("t5_after", 10);
    check("t5_req1_first", 32'({bus.owner, bus.tx_data, bus.cnt1, bus.cnt0}),
          32'({1'b1, 8'hE1, 6'd1, 6'd0}));
    repeat (10) tick();

    // Counter wrap on requester 0
    do_reset();
    keep0 = 1'b1; bus.data0 = 8'h3C; bus.req0 = 1'b1;
    for (int i = 0; i < CMASK; i++) wait_strobe("t6_strobe", 20);
    check("t6_cnt0_max", 32'(bus.cnt0), CMASK);
    wait_strobe("t6_wrap_strobe", 20);
    check("t6_cnt0_wrap", 32'(bus.cnt0), 0);
    check("t6_cnt1_same", 32'(bus.cnt1), 0);
    keep0 = 1'b0; bus.req0 = 1'b0;
    repeat (10) tick();

    // Randomized traffic
    do_reset();
    for (int blk = 0; blk < 12; blk++)
      for (int i = 0; i < 250; i++) rand_cycle(blk % 3);
    @(negedge clk); #1;
    reset = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0; bus.tx_rdy = 1'b1;
    repeat (20) tick();
    check("sb_drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
